// File: rtl/hpdcache_rrarb_hold_if.sv
// Request/grant handshake bundle between hpdcache request sources and the
// round-robin arbiter; master = requesters/downstream side, slave = arbiter.
interface hpdcache_rrarb_hold_if #(
    parameter int N = 4
);
    localparam int Log2N = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     req_i;
    logic [N-1:0]     gnt_o;
    logic [Log2N-1:0] gnt_idx_o;
    logic             valid_o;
    logic             ready_i;

    modport master (
        output req_i,
        output ready_i,
        input  gnt_o,
        input  gnt_idx_o,
        input  valid_o
    );

    modport slave (
        input  req_i,
        input  ready_i,
        output gnt_o,
        output gnt_idx_o,
        output valid_o
    );
endinterface

// File: rtl/hpdcache_rrarb_hold.sv
// Round-robin arbiter with grant hold across a valid/ready handshake.
// Optional saturating stall counter under `HPDCACHE_RRARB_STALL_CNT_EN.
module hpdcache_rrarb_hold #(
    parameter int N = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
`ifdef HPDCACHE_RRARB_STALL_CNT_EN
    input  logic                 stall_cnt_clr_i,
    output logic [15:0]          stall_cnt_o,
`endif
    hpdcache_rrarb_hold_if.slave bus
);
    localparam int Log2N = (N > 1) ? $clog2(N) : 1;

    logic [Log2N-1:0] ptr_q;
    logic [Log2N-1:0] ptr_d;
    logic             lock_q;
    logic [N-1:0]     gnt_q;

    logic [N-1:0]     req;
    logic [N-1:0]     arb_gnt;
    logic [N-1:0]     gnt;
    logic [Log2N-1:0] gnt_idx;
    logic             valid;
    logic             ready;
    logic             handshake;
    logic             stall;

    assign req   = bus.req_i;
    assign ready = bus.ready_i;

    // Scan from ptr_q upward with wrap-around; first requester found wins.
    always_comb begin : rr_scan
        int  idx;
        logic found;
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the tool infers a latch for the paths that skip it.
        arb_gnt = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req[idx]) begin
                arb_gnt[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign gnt   = lock_q ? gnt_q : arb_gnt;
    assign valid = lock_q | (|req);

    // gnt is one-hot or zero, so OR-ing the indices of set bits is the encode.
    always_comb begin : onehot_to_bin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = gnt_idx | Log2N'(i);
            end
        end
    end

    // Next pointer sits just past the accepted requester; stays 0 when N=1.
    assign ptr_d     = Log2N'((int'(gnt_idx) + 1) % N);
    assign handshake = valid & ready;
    assign stall     = valid & ~ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin : arb_state
        if (rst_i) begin
            ptr_q  <= '0;
            lock_q <= 1'b0;
            gnt_q  <= '0;
        end else if (handshake) begin
            ptr_q  <= ptr_d;
            lock_q <= 1'b0;
        end else if (stall) begin
            lock_q <= 1'b1;
            gnt_q  <= gnt;
        end
    end

    assign bus.gnt_o     = gnt;
    assign bus.gnt_idx_o = gnt_idx;
    assign bus.valid_o   = valid;

`ifdef HPDCACHE_RRARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin : stall_counter
        if (rst_i || stall_cnt_clr_i) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    // A requester holding a locked grant must keep its request up.
    req_held_while_locked: assert property (
        @(posedge clk_i) disable iff (rst_i) lock_q |-> req[gnt_idx]
    );

    gnt_onehot0: assert property (
        @(posedge clk_i) disable iff (rst_i) $onehot0(gnt)
    );

    gnt_matches_valid: assert property (
        @(posedge clk_i) disable iff (rst_i) valid == (|gnt)
    );
endmodule

// File: tb/tb_hpdcache_rrarb_hold.sv
// Directed bench for hpdcache_rrarb_hold: N=4 vector table plus N=1 and
// stall-counter sequences (counter part needs HPDCACHE_RRARB_STALL_CNT_EN).
module tb_hpdcache_rrarb_hold;
    logic clk;
    logic rst4;
    logic rst1;
    int   n_vec;
    int   n_bad;

    hpdcache_rrarb_hold_if #(.N(4)) bus4 ();
    hpdcache_rrarb_hold_if #(.N(1)) bus1 ();

`ifdef HPDCACHE_RRARB_STALL_CNT_EN
    logic        stall_cnt_clr;
    logic [15:0] stall_cnt;
`endif

    hpdcache_rrarb_hold #(.N(4)) dut4 (
        .clk_i           (clk),
        .rst_i           (rst4),
`ifdef HPDCACHE_RRARB_STALL_CNT_EN
        .stall_cnt_clr_i (stall_cnt_clr),
        .stall_cnt_o     (stall_cnt),
`endif
        .bus             (bus4.slave)
    );

`ifdef HPDCACHE_RRARB_STALL_CNT_EN
    logic        clr1_unused;
    logic [15:0] cnt1_unused;
    assign clr1_unused = 1'b0;
`endif

    hpdcache_rrarb_hold #(.N(1)) dut1 (
        .clk_i           (clk),
        .rst_i           (rst1),
`ifdef HPDCACHE_RRARB_STALL_CNT_EN
        .stall_cnt_clr_i (clr1_unused),
        .stall_cnt_o     (cnt1_unused),
`endif
        .bus             (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ready;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] req, input logic ready,
                       input logic [3:0] gnt, input logic [1:0] idx, input logic valid);
        vec_t v;
        v.rst = rst; v.req = req; v.ready = ready;
        v.gnt = gnt; v.idx = idx; v.valid = valid;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst4 = 1'b1;
        rst1 = 1'b1;
        bus4.req_i   = '0;
        bus4.ready_i = 1'b0;
        bus1.req_i   = '0;
        bus1.ready_i = 1'b0;
`ifdef HPDCACHE_RRARB_STALL_CNT_EN
        stall_cnt_clr = 1'b0;
`endif

        //   rst  req      rdy  gnt      idx    valid
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0); // reset state, idle
        add(1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1); // basic round-robin
        add(1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1);
        add(1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1);
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0); // reset, ptr back to 0
        add(1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1); // hold: stall locks req 1
        add(1'b0, 4'b0111, 1'b0, 4'b0010, 2'd1, 1'b1); // new req 0 cannot preempt
        add(1'b0, 4'b0111, 1'b0, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1); // accepted
        add(1'b0, 4'b0110, 1'b1, 4'b0100, 2'd2, 1'b1); // next grant idx2, ptr->3
        add(1'b0, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1); // wrap-around
        add(1'b0, 4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1);
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0); // idle, ptr stays 1
        add(1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1); // fairness sweep from 1
        add(1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1); // lock on requester 2
        add(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1); // reset during lock
        add(1'b0, 4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1); // re-arbitrate from 0
        add(1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1); // reset beats handshake
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst4         = vecs[i].rst;
            bus4.req_i   = vecs[i].req;
            bus4.ready_i = vecs[i].ready;
            #1;
            check($sformatf("v%0d gnt", i),   32'(bus4.gnt_o),     32'(vecs[i].gnt));
            check($sformatf("v%0d idx", i),   32'(bus4.gnt_idx_o), 32'(vecs[i].idx));
            check($sformatf("v%0d valid", i), 32'(bus4.valid_o),   32'(vecs[i].valid));
        end

        // N=1: grant follows req, held through a stall, exactly one handshake.
        @(negedge clk);
        rst1 = 1'b0;
        bus1.req_i   = 1'b1;
        bus1.ready_i = 1'b0;
        #1;
        check("n1 stall gnt",   32'(bus1.gnt_o),     32'd1);
        check("n1 stall idx",   32'(bus1.gnt_idx_o), 32'd0);
        @(negedge clk);
        #1;
        check("n1 held gnt",    32'(bus1.gnt_o),     32'd1);
        check("n1 held valid",  32'(bus1.valid_o),   32'd1);
        @(negedge clk);
        bus1.ready_i = 1'b1;
        #1;
        check("n1 accept gnt",  32'(bus1.gnt_o),     32'd1);
        @(negedge clk);
        bus1.req_i   = 1'b0;
        bus1.ready_i = 1'b0;
        #1;
        check("n1 after valid", 32'(bus1.valid_o),   32'd0);
        check("n1 after gnt",   32'(bus1.gnt_o),     32'd0);

`ifdef HPDCACHE_RRARB_STALL_CNT_EN
        @(negedge clk);
        rst4         = 1'b1;
        bus4.req_i   = 4'b0000;
        bus4.ready_i = 1'b0;
        @(negedge clk);
        rst4 = 1'b0;
        #1;
        check("cnt reset", 32'(stall_cnt), 32'd0);
        bus4.req_i = 4'b0001;
        repeat (5) @(posedge clk);
        #1;
        check("cnt 5 stalls", 32'(stall_cnt), 32'd5);
        stall_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        check("cnt clr wins", 32'(stall_cnt), 32'd0);
        stall_cnt_clr = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        check("cnt saturate", 32'(stall_cnt), 32'hFFFF);
        bus4.ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("cnt hold sat", 32'(stall_cnt), 32'hFFFF);
        bus4.req_i   = 4'b0000;
        bus4.ready_i = 1'b0;
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
